parallel2serial_tx: RTL and testbench
=====================================

// Module: parallel2serial_tx
// PURPOSE
//   Transmit end of the byte-serial link: accepts parallel words over a valid/ready
//   handshake and shifts them out one bit per clock with a per-bit valid strobe.
//   The receiving serial2parallel block reassembles the words downstream.
//   A one-entry holding buffer allows back-to-back words with no idle cycle between them.
// PARAMETERS
//   WIDTH      8   bits per word (>=2); bit counter is $clog2(WIDTH) bits wide
//   MSB_FIRST  1   1: transmit din_parallel[WIDTH-1] first; 0: transmit bit 0 first
// PORTS
//   clk            in   1      single clock, all logic on rising edge
//   rst_n          in   1      asynchronous, active-low reset
//   din_parallel   in   WIDTH  word to transmit
//   din_valid      in   1      din_parallel is valid this cycle
//   din_ready      out  1      block can accept a word this cycle
//   dout_serial    out  1      current serial bit
//   dout_valid     out  1      dout_serial carries a data bit this cycle
//   dout_last      out  1      dout_serial is the final bit of the current word
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, cnt=0, buffer empty, shift reg=0;
//     dout_serial=0, dout_valid=0, dout_last=0, din_ready=1.
//   - All outputs are registered. din_ready = !buf_full; it is a register, not a
//     combinational path from din_valid.
//   - Accept: a word is accepted on an edge where din_valid && din_ready.
//   - FSM IDLE: the accepted word loads straight into the shift reg. The state goes to
//     SHIFT and cnt=0. The first bit is on dout with dout_valid=1 in the cycle after the
//     accepting edge (latency 1).
//   - FSM SHIFT: each edge advances one bit and increments cnt.
//     dout_last=1 while cnt==WIDTH-1.
//   - Accepting a word in SHIFT with cnt<WIDTH-1 stores it in the buffer.
//     buf_full=1 and din_ready drops on the next cycle.
//   - End of word (edge leaving cnt==WIDTH-1):
//       buffer full          -> buffer loads into shift reg, cnt=0, buffer empties,
//                               din_ready=1, remain SHIFT
//       buffer empty, word   -> accepted word loads directly into shift reg, cnt=0,
//       accepted same edge      remain SHIFT
//       neither              -> IDLE; dout_valid=0, dout_last=0, dout_serial=0
//   - Continuous streaming therefore gives dout_valid held high with no gaps.
//     Sustained throughput is 1 word per WIDTH cycles.
//   - din_parallel is sampled only on an accepting edge; later changes have no effect.
//   - din_valid while din_ready=0 is ignored. The sender must hold the word until it is
//     accepted.
//   - Reset mid-word: the word in flight and the buffer contents are discarded.
//     Outputs go low immediately. No partial word resumes after reset.
// TESTING
//   1 Reset then idle: rst_n low for 3 cycles with din_valid=0 -> dout_valid=0,
//     dout_serial=0, din_ready=1 throughout.
//   2 Single word 8'hA5, MSB_FIRST=1 -> dout_valid high 8 cycles starting 1 cycle after
//     acceptance; bits 1,0,1,0,0,1,0,1; dout_last on the 8th bit only; then IDLE.
//   3 Back-to-back 8'h3C then 8'hC3, din_valid held -> 16 consecutive valid bits
//     0011110011000011 with no gap. din_ready drops while the buffer is full.
//     dout_last pulses at bits 8 and 16.
//   4 MSB_FIRST=0, word 8'h01 -> first transmitted bit is 1, the next 7 bits are 0.
//   5 Reset asserted at bit 4 of 8'hFF with a second word buffered -> outputs low
//     asynchronously. After release no bits are emitted until a new word is accepted.
//   6 Loopback into serial2parallel, random words -> every received dout_parallel
//     equals the sent word, in order.

Source files
------------

// File: rtl/parallel2serial_tx.sv
// Transmit end of the byte-serial link. Parallel words arrive over a valid/ready
// handshake and are shifted out one bit per clock, with a one-word holding buffer.
module parallel2serial_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_parallel,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout_serial,
    output logic             dout_valid,
    output logic             dout_last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] buf_reg;
    logic             buf_full;
    logic             accept;

    assign accept = din_valid && din_ready;

    // shift_reg holds only the bits still waiting to go out; the bit currently
    // on the line lives in dout_serial so every output stays a plain flop.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shift_reg   <= '0;
            buf_reg     <= '0;
            buf_full    <= 1'b0;
            din_ready   <= 1'b1;
            dout_serial <= 1'b0;
            dout_valid  <= 1'b0;
            dout_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= SHIFT;
                        cnt         <= '0;
                        shift_reg   <= tail(din_parallel);
                        dout_serial <= head_bit(din_parallel);
                        dout_valid  <= 1'b1;
                        dout_last   <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        // Word boundary: the buffered word takes priority; a fresh
                        // word can only arrive here when the buffer is empty.
                        if (buf_full) begin
                            cnt         <= '0;
                            shift_reg   <= tail(buf_reg);
                            dout_serial <= head_bit(buf_reg);
                            dout_last   <= 1'b0;
                            buf_full    <= 1'b0;
                            din_ready   <= 1'b1;
                        end else if (accept) begin
                            cnt         <= '0;
                            shift_reg   <= tail(din_parallel);
                            dout_serial <= head_bit(din_parallel);
                            dout_last   <= 1'b0;
                        end else begin
                            state       <= IDLE;
                            cnt         <= '0;
                            dout_serial <= 1'b0;
                            dout_valid  <= 1'b0;
                            dout_last   <= 1'b0;
                        end
                    end else begin
                        cnt         <= cnt + 1'b1;
                        shift_reg   <= tail(shift_reg);
                        dout_serial <= head_bit(shift_reg);
                        dout_last   <= (cnt == CNT_LAST - 1'b1);
                        if (accept) begin
                            buf_reg   <= din_parallel;
                            buf_full  <= 1'b1;
                            din_ready <= 1'b0;
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    dout_valid <= 1'b0;
                    dout_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parallel2serial_tx.sv
// Directed bench for parallel2serial_tx: one MSB-first and one LSB-first instance,
// table-driven single words plus hand-written back-to-back, reset and loopback sequences.
module tb_parallel2serial_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din_a = '0, din_b = '0;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic       ready_a, serial_a, dvalid_a, last_a;
    logic       ready_b, serial_b, dvalid_b, last_b;

    int n_compared = 0;
    int n_mismatched = 0;

    logic       rx_en = 1'b0;
    logic [7:0] rx_acc = '0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    parallel2serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .din_parallel(din_a), .din_valid(valid_a),
        .din_ready(ready_a), .dout_serial(serial_a), .dout_valid(dvalid_a), .dout_last(last_a)
    );

    parallel2serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .din_parallel(din_b), .din_valid(valid_b),
        .din_ready(ready_b), .dout_serial(serial_b), .dout_valid(dvalid_b), .dout_last(last_b)
    );

    // Bench-side receiver: reassembles MSB-first words from the serial stream.
    always @(negedge clk) begin
        if (rx_en && dvalid_a) begin
            rx_acc = {rx_acc[6:0], serial_a};
            if (last_a) rx_q.push_back(rx_acc);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic get_ready(input logic sel);
        return sel ? ready_b : ready_a;
    endfunction
    function automatic logic get_serial(input logic sel);
        return sel ? serial_b : serial_a;
    endfunction
    function automatic logic get_dvalid(input logic sel);
        return sel ? dvalid_b : dvalid_a;
    endfunction
    function automatic logic get_last(input logic sel);
        return sel ? last_b : last_a;
    endfunction

    // Offers one word and returns at the negedge just after the accepting edge.
    task automatic applyStimulus(input logic sel, input logic [7:0] word);
        logic r;
        @(negedge clk);
        if (sel) begin din_b = word; valid_b = 1'b1; end
        else     begin din_a = word; valid_a = 1'b1; end
        r = get_ready(sel);
        for (int t = 0; t < 20 && !r; t++) begin
            @(negedge clk);
            r = get_ready(sel);
        end
        if (!r) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        din_a = 8'h00;
        din_b = 8'h00;
    endtask

    // Checks one word in transmission order; exp_seq[7] is the first bit on the line.
    task automatic collectWord(input logic sel, input logic [7:0] exp_seq, input string tag);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput($sformatf("%s_valid%0d", tag, k), {31'd0, get_dvalid(sel)}, 32'd1);
            checkOutput($sformatf("%s_bit%0d", tag, k), {31'd0, get_serial(sel)}, {31'd0, exp_seq[7-k]});
            checkOutput($sformatf("%s_last%0d", tag, k), {31'd0, get_last(sel)}, (k == 7) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        checkOutput({tag, "_idle_valid"}, {31'd0, get_dvalid(sel)}, 32'd0);
        checkOutput({tag, "_idle_last"}, {31'd0, get_last(sel)}, 32'd0);
        checkOutput({tag, "_idle_serial"}, {31'd0, get_serial(sel)}, 32'd0);
    endtask

    typedef struct {
        logic       use_lsb;
        logic [7:0] word;
        logic [7:0] exp_seq;
        string      tag;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0] b2b_seq;
        logic [7:0]  w;
        logic        r;
        int          sent;

        vecs[0] = '{1'b0, 8'hA5, 8'b10100101, "msb_a5"};
        vecs[1] = '{1'b0, 8'h80, 8'b10000000, "msb_80"};
        vecs[2] = '{1'b0, 8'h3A, 8'b00111010, "msb_3a"};
        vecs[3] = '{1'b1, 8'h01, 8'b10000000, "lsb_01"};
        vecs[4] = '{1'b1, 8'h3A, 8'b01011100, "lsb_3a"};

        $display("[TB] reset and idle");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_dvalid_a", {31'd0, dvalid_a}, 32'd0);
            checkOutput("rst_serial_a", {31'd0, serial_a}, 32'd0);
            checkOutput("rst_ready_a", {31'd0, ready_a}, 32'd1);
            checkOutput("rst_ready_b", {31'd0, ready_b}, 32'd1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_dvalid_b", {31'd0, dvalid_b}, 32'd0);

        $display("[TB] single-word table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].use_lsb, vecs[i].word);
            collectWord(vecs[i].use_lsb, vecs[i].exp_seq, vecs[i].tag);
        end

        $display("[TB] back-to-back 3C then C3");
        b2b_seq = 16'b0011110011000011;
        @(negedge clk);
        din_a = 8'h3C;
        valid_a = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) din_a = 8'hC3;
            if (k == 1) valid_a = 1'b0;
            checkOutput($sformatf("b2b_valid%0d", k), {31'd0, dvalid_a}, 32'd1);
            checkOutput($sformatf("b2b_bit%0d", k), {31'd0, serial_a}, {31'd0, b2b_seq[15-k]});
            checkOutput($sformatf("b2b_last%0d", k), {31'd0, last_a}, (k == 7 || k == 15) ? 32'd1 : 32'd0);
            checkOutput($sformatf("b2b_ready%0d", k), {31'd0, ready_a}, (k >= 1 && k <= 7) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        checkOutput("b2b_end_valid", {31'd0, dvalid_a}, 32'd0);

        $display("[TB] reset mid-word with buffered word");
        @(negedge clk);
        din_a = 8'hFF;
        valid_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) din_a = 8'h55;
            if (k == 1) valid_a = 1'b0;
        end
        checkOutput("mid_buffer_full", {31'd0, ready_a}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_dvalid", {31'd0, dvalid_a}, 32'd0);
        checkOutput("async_serial", {31'd0, serial_a}, 32'd0);
        checkOutput("async_last", {31'd0, last_a}, 32'd0);
        checkOutput("async_ready", {31'd0, ready_a}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checkOutput($sformatf("post_rst_quiet%0d", k), {31'd0, dvalid_a}, 32'd0);
        end
        applyStimulus(1'b0, 8'h81);
        collectWord(1'b0, 8'b10000001, "post_rst_81");

        $display("[TB] loopback stream");
        rx_q.delete();
        tx_q.delete();
        rx_acc = '0;
        rx_en = 1'b1;
        sent = 0;
        w = 8'($urandom);
        @(negedge clk);
        din_a = w;
        valid_a = 1'b1;
        r = ready_a;
        for (int c = 0; c < 400 && sent < 12; c++) begin
            @(negedge clk);
            if (r) begin
                tx_q.push_back(w);
                sent++;
                if (sent < 12) begin
                    w = 8'($urandom);
                    din_a = w;
                end else begin
                    valid_a = 1'b0;
                end
            end
            r = ready_a;
        end
        valid_a = 1'b0;
        checkOutput("loop_sent", sent, 32'd12);
        for (int c = 0; c < 60 && rx_q.size() < tx_q.size(); c++) @(negedge clk);
        checkOutput("loop_rx_count", rx_q.size(), tx_q.size());
        for (int i = 0; i < tx_q.size() && i < rx_q.size(); i++) begin
            checkOutput($sformatf("loop_word%0d", i), {24'd0, rx_q[i]}, {24'd0, tx_q[i]});
        end
        rx_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
